// File: rtl/kalman_meas_ctrl.sv
//==============================================================================
// kalman_meas_ctrl : per-frame measurement sequencer feeding a kalman filter core
// Optional build macro: KALMAN_MEAS_CTRL_STATS_EN (drop_cnt / coast_cnt outputs)
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module kalman_meas_ctrl #(
  parameter int DISP_WIDTH = 11,
  parameter int MAX_COAST  = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  frame_start,
  input  logic                  det_valid,
  input  logic [DISP_WIDTH-1:0] det_x,
  input  logic [DISP_WIDTH-1:0] det_y,
  output logic                  kf_valid,
  input  logic                  kf_ready,
  output logic [DISP_WIDTH-1:0] kf_z_x,
  output logic [DISP_WIDTH-1:0] kf_z_y,
  input  logic [DISP_WIDTH-1:0] kf_x_est,
  input  logic [DISP_WIDTH-1:0] kf_y_est,
  output logic                  est_valid,
  output logic [DISP_WIDTH-1:0] est_x,
  output logic [DISP_WIDTH-1:0] est_y,
  output logic                  lost,
  output logic                  timeout_err
`ifdef KALMAN_MEAS_CTRL_STATS_EN
  ,
  output logic [15:0]           drop_cnt,
  output logic [15:0]           coast_cnt
`endif
);

  localparam logic [3:0]  c_MAX_COAST = 4'(MAX_COAST);
  localparam logic [15:0] c_TMO_LAST  = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                state_q;
  logic                  kf_valid_q;
  logic                  est_valid_q;
  logic [DISP_WIDTH-1:0] est_x_q, est_y_q;
  logic                  timeout_err_q;
  logic [15:0]           tmo_q;

  logic                  slot_full_q, slot_full_d;
  logic [DISP_WIDTH-1:0] slot_x_q, slot_x_d;
  logic [DISP_WIDTH-1:0] slot_y_q, slot_y_d;

  logic                  frame_open_q;
  logic                  got_det_q;
  logic [3:0]            miss_q;
  logic                  lost_q;

  logic w_acc;
  logic w_done_cap;
  logic w_tmo_hit;
  logic w_eval;
  logic w_got;
  logic w_coast;

  assign w_acc      = (state_q == ST_ISSUE) && kf_valid_q && kf_ready;
  assign w_done_cap = (state_q == ST_DONE) && kf_ready;
  // Forward progress on the handshake takes precedence over an abort in the same cycle
  assign w_tmo_hit  = (state_q != ST_IDLE) && (tmo_q == c_TMO_LAST) && !w_acc && !w_done_cap;

  // A detection arriving with frame_start belongs to the frame that is ending
  assign w_eval  = frame_start && frame_open_q;
  assign w_got   = got_det_q || det_valid;
  assign w_coast = w_eval && !w_got && (miss_q < c_MAX_COAST);

  always_comb begin
    slot_full_d = slot_full_q;
    slot_x_d    = slot_x_q;
    slot_y_d    = slot_y_q;
    if (w_acc || w_tmo_hit) begin
      slot_full_d = 1'b0;
    end
    if (w_coast) begin
      slot_full_d = 1'b1;
      slot_x_d    = kf_x_est;
      slot_y_d    = kf_y_est;
    end
    if (det_valid) begin
      slot_full_d = 1'b1;
      slot_x_d    = det_x;
      slot_y_d    = det_y;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      slot_full_q <= 1'b0;
      slot_x_q    <= '0;
      slot_y_q    <= '0;
    end else begin
      slot_full_q <= slot_full_d;
      slot_x_q    <= slot_x_d;
      slot_y_q    <= slot_y_d;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      frame_open_q <= 1'b0;
      got_det_q    <= 1'b0;
      miss_q       <= '0;
      lost_q       <= 1'b0;
    end else if (frame_start) begin
      frame_open_q <= 1'b1;
      got_det_q    <= 1'b0;
      if (frame_open_q) begin
        if (w_got) begin
          miss_q <= '0;
          lost_q <= 1'b0;
        end else if (miss_q < c_MAX_COAST) begin
          miss_q <= miss_q + 4'd1;
        end else begin
          lost_q <= 1'b1;
        end
      end
    end else if (det_valid) begin
      got_det_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= ST_IDLE;
      kf_valid_q    <= 1'b0;
      est_valid_q   <= 1'b0;
      est_x_q       <= '0;
      est_y_q       <= '0;
      timeout_err_q <= 1'b0;
      tmo_q         <= '0;
    end else begin
      est_valid_q <= 1'b0;
      if (w_tmo_hit) begin
        state_q       <= ST_IDLE;
        kf_valid_q    <= 1'b0;
        timeout_err_q <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (slot_full_q) begin
              state_q    <= ST_ISSUE;
              kf_valid_q <= 1'b1;
              tmo_q      <= '0;
            end
          end
          ST_ISSUE: begin
            tmo_q <= tmo_q + 16'd1;
            if (w_acc) begin
              state_q    <= ST_BUSY;
              kf_valid_q <= 1'b0;
            end
          end
          ST_BUSY: begin
            tmo_q <= tmo_q + 16'd1;
            if (!kf_ready) begin
              state_q <= ST_DONE;
            end
          end
          ST_DONE: begin
            tmo_q <= tmo_q + 16'd1;
            if (kf_ready) begin
              state_q     <= ST_IDLE;
              est_x_q     <= kf_x_est;
              est_y_q     <= kf_y_est;
              est_valid_q <= 1'b1;
            end
          end
          default: begin
            state_q    <= ST_IDLE;
            kf_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign kf_valid    = kf_valid_q;
  assign kf_z_x      = slot_x_q;
  assign kf_z_y      = slot_y_q;
  assign est_valid   = est_valid_q;
  assign est_x       = est_x_q;
  assign est_y       = est_y_q;
  assign lost        = lost_q;
  assign timeout_err = timeout_err_q;

`ifdef KALMAN_MEAS_CTRL_STATS_EN
  logic [15:0] drop_cnt_q;
  logic [15:0] coast_cnt_q;

  // A write racing the acceptance of the slot does not lose the accepted value
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      drop_cnt_q  <= '0;
      coast_cnt_q <= '0;
    end else begin
      if (det_valid && slot_full_q && !w_acc && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
      if (w_coast && (coast_cnt_q != 16'hFFFF)) begin
        coast_cnt_q <= coast_cnt_q + 16'd1;
      end
    end
  end

  assign drop_cnt  = drop_cnt_q;
  assign coast_cnt = coast_cnt_q;
`endif

endmodule

`default_nettype wire

// File: doc/kalman_meas_ctrl.md
Name: kalman_meas_ctrl

Overview:
Sequencer between the per-frame object detector and the kalman filter core. It buffers one centroid measurement per video frame and issues it to the filter over its valid/ready handshake. When a frame has no detection it feeds the filter's last estimate back as a coast measurement, and it declares track loss after too many misses. Each completed filter update is presented downstream as a single-cycle estimate pulse.

Parameters:
DISP_WIDTH, 11, width of x/y display coordinates
MAX_COAST, 4, consecutive missed frames allowed before lost asserts (1..15)
TIMEOUT, 1023, cycles allowed in ISSUE+BUSY+DONE before abort (fits 16 bits)

Ports:
clk  in  1  clock
aresetn  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse at start of each frame (vsync-derived)
det_valid  in  1  one-cycle pulse: detector centroid valid
det_x  in  DISP_WIDTH  detected x
det_y  in  DISP_WIDTH  detected y
kf_valid  out  1  measurement valid to filter
kf_ready  in  1  filter idle/accepting
kf_z_x  out  DISP_WIDTH  measurement x to filter
kf_z_y  out  DISP_WIDTH  measurement y to filter
kf_x_est  in  DISP_WIDTH  filter current x estimate
kf_y_est  in  DISP_WIDTH  filter current y estimate
est_valid  out  1  one-cycle pulse: new estimate on est_x/est_y
est_x  out  DISP_WIDTH  latched estimate x
est_y  out  DISP_WIDTH  latched estimate y
lost  out  1  track lost (miss limit reached)
timeout_err  out  1  sticky: filter handshake timed out

Behaviour:
- Reset: clk, aresetn asynchronous active-low. All outputs 0. FSM in IDLE. Slot empty. miss_cnt=0. got_det=0. frame_open=0.
- Slot: one-deep buffer {x,y}.
  - det_valid writes det_x/det_y into the slot and sets got_det; latest write wins.
  - A write to an already-full slot overwrites it and increments drop_cnt (stats build only).
  - det_valid is accepted in every FSM state.
- frame_start end-of-frame evaluation, applied only if frame_open=1; frame_start always sets frame_open=1 and clears got_det:
  - got_det=1: miss_cnt<=0, lost<=0.
  - got_det=0 and miss_cnt<MAX_COAST: slot<=kf_x_est/kf_y_est (coast), miss_cnt++.
  - got_det=0 and miss_cnt==MAX_COAST: lost<=1, no coast load, miss_cnt holds.
- det_valid and frame_start in the same cycle: the detection counts for the ending frame. got_det is treated as 1, the slot takes det data, and the new frame starts with got_det=0.
- Detection while lost=1: lost clears at the next frame_start evaluation.
- FSM:
  - IDLE: slot full goes to ISSUE.
  - ISSUE: kf_valid=1 with kf_z_x/kf_z_y driven from the slot. When kf_valid&kf_ready, the slot clears (unless written the same cycle) and the FSM goes to BUSY.
  - BUSY: kf_valid=0; kf_ready=0 goes to DONE.
  - DONE: kf_ready=1 captures kf_x_est/kf_y_est into est_x/est_y, pulses est_valid the next cycle, and returns to IDLE.
- kf_valid is registered. It deasserts the cycle after acceptance, so the filter never sees two valids for one measurement.
- Latency: with a full slot in IDLE and kf_ready=1, kf_valid asserts 1 cycle later.
- Timeout: a 16-bit counter resets on entering ISSUE and counts in ISSUE/BUSY/DONE.
  - Reaching TIMEOUT sets timeout_err (sticky until reset), drops the slot, and returns to IDLE.
  - kf_valid=0 that cycle.
- est_x/est_y hold their value between pulses.
- aresetn mid-operation aborts immediately to reset values; any in-flight measurement is lost.

Optional Feature:
KALMAN_MEAS_CTRL_STATS_EN: adds outputs drop_cnt[15:0] (slot overwrites) and coast_cnt[15:0] (coast loads). Both are saturating and reset to 0. Without the macro these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- frame_start, then det_valid (100,200), filter model with ready low for 8 cycles -> kf_valid one cycle with (100,200); est_valid pulses once with the model's estimate; lost=0.
- Model estimate (50,60), then 3 frames with no detection -> three coast issues each carrying (50,60); miss_cnt=3; lost=0.
- MAX_COAST=4, 5 empty frames -> 4 coast issues, then lost=1 with no 5th issue; a detection at (10,10) plus frame_start -> lost=0, issue (10,10).
- Two det_valid pulses (1,1) then (2,2) while filter busy -> single issue of (2,2); drop_cnt=1 in the stats build.
- det_valid (7,9) coincident with frame_start -> no coast load; (7,9) issued; miss_cnt=0.
- kf_ready held 0 in ISSUE for TIMEOUT cycles -> timeout_err=1, FSM back in IDLE, kf_valid=0; a later aresetn pulse -> all outputs 0.
